// File: rtl/fetch_prefetch_if.sv
// Bus bundle for the fetch unit: instruction-memory req/gnt/rvalid port,
// redirect strobe and the decode-side valid/ready handshake.
interface fetch_prefetch_if #(
    parameter int XLEN = 32
) ();
    logic            instr_req_out;
    logic [XLEN-1:0] instr_addr_out;
    logic            gnt_in;
    logic            instr_rvalid_in;
    logic [XLEN-1:0] instr_rdata_in;
    logic            redirect_in;
    logic [XLEN-1:0] redirect_target_in;
    logic            instr_valid_out;
    logic            instr_ready_in;
    logic [XLEN-1:0] instr_out;
    logic [XLEN-1:0] pc_out;
    logic            resp_err_out;

    // The fetch unit itself.
    modport master (
        output instr_req_out, instr_addr_out, instr_valid_out, instr_out, pc_out, resp_err_out,
        input  gnt_in, instr_rvalid_in, instr_rdata_in, redirect_in, redirect_target_in,
        input  instr_ready_in
    );

    // Memory, branch unit and decode seen together from the outside.
    modport slave (
        input  instr_req_out, instr_addr_out, instr_valid_out, instr_out, pc_out, resp_err_out,
        output gnt_in, instr_rvalid_in, instr_rdata_in, redirect_in, redirect_target_in,
        output instr_ready_in
    );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction fetch unit: credit-limited sequential requests into an in-order
// prefetch FIFO that feeds decode; a redirect flushes and restarts at the target.
module fetch_prefetch #(
    parameter int              XLEN            = 32,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] BOOT_ADDR       = '0,
    parameter int              PC_STEP         = 4
) (
    input logic              clk_in,
    input logic              rst_in,
    fetch_prefetch_if.master bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = CW + 1;
    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t          fifo_mem [FIFO_DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   outstanding_nxt;
    logic [OW-1:0]   discard;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] target_aligned;
    logic            resp_err;

    logic issue_ok;
    logic granted;
    logic resp_ok;
    logic spurious;
    logic dropping;
    logic push;
    logic pop;
    logic empty;
    logic out_en;
    logic valid;

    // Requests in flight plus buffered words never exceed the FIFO, so a
    // returning word always has a free slot even if decode never pops.
    assign issue_ok = (outstanding < OW'(MAX_OUTSTANDING)) &&
                      ((SW'(outstanding) + SW'(count)) < SW'(FIFO_DEPTH));

    assign granted         = bus.instr_req_out && bus.gnt_in;
    assign resp_ok         = bus.instr_rvalid_in && (outstanding != '0);
    assign spurious        = bus.instr_rvalid_in && (outstanding == '0);
    assign dropping        = discard != '0;
    assign push            = resp_ok && !dropping && !bus.redirect_in;
    assign empty           = count == '0;
    assign out_en          = !rst_in && !empty;
    assign valid           = out_en && !bus.redirect_in;
    assign pop             = valid && bus.instr_ready_in;
    assign outstanding_nxt = outstanding + OW'(granted) - OW'(resp_ok);
    assign target_aligned  = bus.redirect_target_in & ALIGN_MASK;
    assign head            = fifo_mem[rd_ptr];

    assign bus.instr_req_out   = !rst_in && issue_ok;
    assign bus.instr_addr_out  = fetch_pc;
    assign bus.instr_valid_out = valid;
    assign bus.instr_out       = out_en ? head.instr : '0;
    assign bus.pc_out          = out_en ? head.pc : '0;
    assign bus.resp_err_out    = resp_err;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fetch_pc    <= BOOT_ADDR;
            resp_pc     <= BOOT_ADDR;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            resp_err    <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;
            if (spurious) begin
                resp_err <= 1'b1;
            end
            if (bus.redirect_in) begin
                // Everything still in flight after this cycle's accounting,
                // including a grant taken this very cycle, is now stale.
                fetch_pc <= target_aligned;
                resp_pc  <= target_aligned;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                discard  <= outstanding_nxt;
            end else begin
                if (granted) begin
                    fetch_pc <= fetch_pc + STEP;
                end
                if (resp_ok && dropping) begin
                    discard <= discard - OW'(1);
                end
                if (push) begin
                    wr_ptr  <= wr_ptr + PW'(1);
                    resp_pc <= resp_pc + STEP;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // NOTE: the storage array has no reset; count gates every read, so stale
    // contents are never visible and the array can map onto plain flops/RAM.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{pc: resp_pc, instr: bus.instr_rdata_in};
        end
    end
endmodule
